// File: rtl/byte_switch.sv
// rtl/byte_switch.sv - registered byte gate with active flag and saturating enabled-cycle counter (option: BYTE_SWITCH_HOLD_EN)
module byte_switch #(
  parameter int                 WIDTH     = 8,
  parameter logic [WIDTH-1:0]   OFF_VALUE = '0,
  parameter int                 CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in,
  input  logic             enable,
  output logic [WIDTH-1:0] out,
  output logic             out_active,
  output logic [CNT_W-1:0] en_cnt
);

  logic [WIDTH-1:0] r_out;
  logic             r_active;
  logic [CNT_W-1:0] r_en_cnt;

  logic [WIDTH-1:0] w_out_next;
  logic             w_cnt_full;
  logic [CNT_W-1:0] w_cnt_next;

  // Select what the data register loads: the input while enabled, otherwise the
  // gated value (or the current value when the hold option keeps it latched).
  always_comb begin
    w_out_next = r_out;
    if (enable) begin
      w_out_next = in;
    end else begin
`ifdef BYTE_SWITCH_HOLD_EN
      w_out_next = r_out;
`else
      w_out_next = OFF_VALUE;
`endif
    end
  end

  // Counter advances only on enabled cycles and sticks at all-ones.
  always_comb begin
    w_cnt_full = &r_en_cnt;
    w_cnt_next = r_en_cnt;
    if (enable && !w_cnt_full) begin
      w_cnt_next = r_en_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Data path register; reset forces the isolation value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out <= OFF_VALUE;
    end else begin
      r_out <= w_out_next;
    end
  end

  // Status flag mirrors the enable sampled on the last edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_active <= 1'b0;
    end else begin
      r_active <= enable;
    end
  end

  // Debug counter of enabled cycles, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_en_cnt <= '0;
    end else begin
      r_en_cnt <= w_cnt_next;
    end
  end

  assign out        = r_out;
  assign out_active = r_active;
  assign en_cnt     = r_en_cnt;

endmodule

// File: tb/tb_byte_switch.sv
// tb/tb_byte_switch.sv - self-checking bench for byte_switch (honours BYTE_SWITCH_HOLD_EN)
`timescale 1ns/1ps
module tb_byte_switch;

  logic        clk;
  logic        rst_n;
  logic [7:0]  in;
  logic        enable;
  logic [7:0]  out;
  logic        out_active;
  logic [15:0] en_cnt;
  logic [7:0]  s_out;
  logic        s_active;
  logic [3:0]  s_cnt;

  int n_cmp;
  int n_fail;

  // Reference state: what the outputs must show, derived from the sampled inputs.
  logic [7:0] m_out;
  logic       m_act;
  int         m_n;

  byte_switch #(.WIDTH(8), .OFF_VALUE(8'h00), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .in(in), .enable(enable),
    .out(out), .out_active(out_active), .en_cnt(en_cnt)
  );

  byte_switch #(.WIDTH(8), .OFF_VALUE(8'h00), .CNT_W(4)) u_sat (
    .clk(clk), .rst_n(rst_n), .in(in), .enable(enable),
    .out(s_out), .out_active(s_active), .en_cnt(s_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural reference: unbounded count of enabled edges, output value chosen by rule.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_out <= 8'h00;
      m_act <= 1'b0;
      m_n   <= 0;
    end else begin
      m_act <= enable;
      if (enable) begin
        m_out <= in;
        m_n   <= m_n + 1;
      end else begin
`ifdef BYTE_SWITCH_HOLD_EN
        m_out <= m_out;
`else
        m_out <= 8'h00;
`endif
      end
    end
  end

  // Per-cycle comparison away from the active edge.
  always @(negedge clk) begin
    check("out",        32'(out),        32'(m_out));
    check("out_active", 32'(out_active), 32'(m_act));
    check("en_cnt",     32'(en_cnt),     32'((m_n > 65535) ? 65535 : m_n));
    check("sat_out",    32'(s_out),      32'(m_out));
    check("sat_cnt",    32'(s_cnt),      32'((m_n > 15) ? 15 : m_n));
  end

  task automatic do_reset();
    @(negedge clk);
    #1 rst_n = 1'b0;
    in = 8'h00;
    enable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0] vin  [6];
    logic       ven  [6];
    logic [7:0] vexp [6];
    n_cmp  = 0;
    n_fail = 0;
    vin  = '{8'h01, 8'h00, 8'h7f, 8'h20, 8'hff, 8'h80};
    ven  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
`ifdef BYTE_SWITCH_HOLD_EN
    vexp = '{8'h01, 8'h01, 8'h7f, 8'h7f, 8'hff, 8'hff};
`else
    vexp = '{8'h01, 8'h00, 8'h7f, 8'h00, 8'hff, 8'h00};
`endif

    // Reset held with active inputs and running clock.
    rst_n  = 1'b0;
    in     = 8'hff;
    enable = 1'b1;
    repeat (4) @(negedge clk);
    check("rst_out",    32'(out),        32'h00);
    check("rst_active", 32'(out_active), 32'h0);
    check("rst_cnt",    32'(en_cnt),     32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_out",    32'(out),        32'hff);
    check("rel_active", 32'(out_active), 32'h1);
    check("rel_cnt",    32'(en_cnt),     32'h1);

    // Pass/gate sequence, ten clocks per step.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      in     = vin[i];
      enable = ven[i];
      repeat (10) @(negedge clk);
      check($sformatf("seq_out%0d", i), 32'(out), 32'(vexp[i]));
      check($sformatf("seq_act%0d", i), 32'(out_active), 32'(ven[i]));
    end
    check("seq_cnt", 32'(en_cnt), 32'd30);

    // Saturation of the narrow counter.
    do_reset();
    in     = 8'h55;
    enable = 1'b1;
    repeat (20) @(negedge clk);
    check("sat_cnt15", 32'(s_cnt),  32'hf);
    check("wide_cnt20", 32'(en_cnt), 32'd20);
    repeat (3) @(negedge clk);
    check("sat_stay", 32'(s_cnt), 32'hf);

    // Asynchronous reset between edges.
    do_reset();
    in     = 8'h7f;
    enable = 1'b1;
    repeat (5) @(negedge clk);
    check("pre_cnt", 32'(en_cnt), 32'd5);
    check("pre_out", 32'(out),    32'h7f);
    #2 rst_n = 1'b0;
    #1;
    check("async_out",    32'(out),        32'h00);
    check("async_cnt",    32'(en_cnt),     32'h0);
    check("async_active", 32'(out_active), 32'h0);
    check("async_sat",    32'(s_cnt),      32'h0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("resume_out", 32'(out),    32'h7f);
    check("resume_cnt", 32'(en_cnt), 32'h1);

    repeat (2) @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
